// File: rtl/mem_ctrl_moc_pkg.sv
// Shared encodings for mem_ctrl_moc: access size, read/write flag and FSM states.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } mem_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_ctrl_moc_if.sv
// MFA/MOC request bus between the control unit (master) and the memory unit (slave).
interface mem_ctrl_moc_if #(
  parameter int ADDR_W = 9
);
  logic              MFA;
  logic              RW;
  logic [1:0]        TYPE;
  logic [ADDR_W-1:0] ADDR;
  logic [31:0]       DATA_IN;
  logic [31:0]       DATA_OUT;
  logic              MOC;
  logic              BUSY;
  logic              ALIGN_ERR;

  modport master (
    output MFA, RW, TYPE, ADDR, DATA_IN,
    input  DATA_OUT, MOC, BUSY, ALIGN_ERR
  );

  modport slave (
    input  MFA, RW, TYPE, ADDR, DATA_IN,
    output DATA_OUT, MOC, BUSY, ALIGN_ERR
  );
endinterface

// File: rtl/mem_ctrl_moc_wait_timer.sv
// moc_wait_timer: loadable 4-bit down-counter that stops at zero; paces the WAIT state.
module moc_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       zero
);

  logic [3:0] r_count;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign zero = (r_count == 4'd0);

endmodule

// File: rtl/mem_ctrl_moc.sv
// mem_ctrl_moc: byte-addressable big-endian RAM behind the MFA/MOC handshake.
// Define MEM_CTRL_ALIGN_CHECK_EN to flag/suppress misaligned accesses instead of aligning them.
module mem_ctrl_moc
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic           CLK,
  input logic           RESET,
  mem_ctrl_moc_if.slave bus
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_VAL = 4'(WAIT_CYCLES);

  mem_state_e        r_state, w_next;
  logic              r_rw;
  mem_type_e         r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic [31:0]       r_dout;
  logic [7:0]        r_mem [DEPTH];

  logic              w_load, w_dec, w_zero, w_access, w_suppress;
  logic [ADDR_W-1:0] w_eff_addr;
  logic [ADDR_W-1:0] w_lane_addr [4];
  logic [3:0]        w_lane_we;
  logic [7:0]        w_lane_wd [4];
  logic [31:0]       w_rdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.MFA) begin
          w_load = 1'b1;
          w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_zero) w_next = S_ACCESS;
        else        w_dec  = 1'b1;
      end
      S_ACCESS: w_next = S_DONE;
      S_DONE:   if (!bus.MFA) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_access = (r_state == S_ACCESS);

  moc_wait_timer u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .i_load     (w_load),
    .i_load_val (WAIT_VAL),
    .i_dec      (w_dec),
    .zero       (w_zero)
  );

  // Request is frozen at acceptance; bus inputs are ignored until the next IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rw   <= RW_READ;
      r_type <= MEM_BYTE;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_load) begin
      r_rw   <= bus.RW;
      r_type <= mem_type_e'(bus.TYPE);
      r_addr <= bus.ADDR;
      r_din  <= bus.DATA_IN;
    end
  end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_align_err;

  assign w_misaligned = (r_type == MEM_RSVD)
                     || ((r_type == MEM_HALF) && r_addr[0])
                     || ((r_type == MEM_WORD) && (r_addr[1:0] != 2'b00));
  assign w_eff_addr   = r_addr;
  assign w_suppress   = w_misaligned;

  // Flag rises with the suppressed access and falls together with MOC.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                r_align_err <= 1'b0;
    else if (w_access)                        r_align_err <= w_misaligned;
    else if ((r_state == S_DONE) && !bus.MFA) r_align_err <= 1'b0;
  end

  assign bus.ALIGN_ERR = r_align_err;
`else
  always_comb begin
    w_eff_addr = r_addr;
    case (r_type)
      MEM_HALF: w_eff_addr[0]   = 1'b0;
      MEM_WORD: w_eff_addr[1:0] = 2'b00;
      default:  ;
    endcase
  end

  assign w_suppress    = (r_type == MEM_RSVD);
  assign bus.ALIGN_ERR = 1'b0;
`endif

  // Lane k addresses byte A+k; lane 0 is always the most significant byte.
  always_comb begin
    w_lane_we = '0;
    for (int k = 0; k < 4; k++) begin
      w_lane_addr[k] = w_eff_addr + ADDR_W'(k);
      w_lane_wd[k]   = 8'h00;
    end
    if (w_access && (r_rw == RW_WRITE) && !w_suppress) begin
      case (r_type)
        MEM_BYTE: begin
          w_lane_we    = 4'b0001;
          w_lane_wd[0] = r_din[7:0];
        end
        MEM_HALF: begin
          w_lane_we    = 4'b0011;
          w_lane_wd[0] = r_din[15:8];
          w_lane_wd[1] = r_din[7:0];
        end
        MEM_WORD: begin
          w_lane_we    = 4'b1111;
          w_lane_wd[0] = r_din[31:24];
          w_lane_wd[1] = r_din[23:16];
          w_lane_wd[2] = r_din[15:8];
          w_lane_wd[3] = r_din[7:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; contents survive RESET and only lanes with an enable change.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (w_lane_we[k]) r_mem[w_lane_addr[k]] <= w_lane_wd[k];
    end
  end

  always_comb begin
    w_rdata = r_dout;
    case (r_type)
      MEM_BYTE: w_rdata = {24'h0, r_mem[w_lane_addr[0]]};
      MEM_HALF: w_rdata = {16'h0, r_mem[w_lane_addr[0]], r_mem[w_lane_addr[1]]};
      MEM_WORD: w_rdata = {r_mem[w_lane_addr[0]], r_mem[w_lane_addr[1]],
                           r_mem[w_lane_addr[2]], r_mem[w_lane_addr[3]]};
      default:  w_rdata = r_dout;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                           r_dout <= 32'h0;
    else if (w_access && (r_rw == RW_READ) && !w_suppress) r_dout <= w_rdata;
  end

  assign bus.DATA_OUT = r_dout;
  assign bus.MOC      = (r_state == S_DONE);
  assign bus.BUSY     = (r_state != S_IDLE);

endmodule
